// File: rtl/core_pkg.sv
// Pipeline-register and memory-port types shared between fetch and decode.
package core;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    localparam if_id_t if_id_rst = '{pc: 32'h0, inst: rv32i::nop, valid: 1'b0};

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} if_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } imem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } imem_rsp_t;

    // Sequential PC; wraps modulo 2^32 and leaves the low bits untouched.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/rv32i_pkg.sv
// RV32I ISA constants shared by the front end of the core.
package rv32i;

    localparam logic [31:0] nop = 32'h0000_0013;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding fetch at a time
// and hands {pc, inst, valid} to decode through the if_id register.
module if_stage
    import core::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        next_rdy,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_rdy,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output if_id_t      if_id,
    output logic        rdy
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] hold_q, hold_d;
    if_id_t      if_id_q, if_id_d;
    imem_req_t   req;
    imem_rsp_t   rsp;

    // A redirect suppresses the request so it can never coincide with acceptance.
    always_comb begin
        req.valid = (state_q == S_REQ) && en && !redir_valid && !rst;
        req.addr  = pc_q;
        rsp.valid = imem_rsp_valid;
        rsp.data  = imem_rsp_data;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        hold_d  = hold_q;
        if_id_d = if_id_q;
        if (next_rdy) begin
            if_id_d.valid = 1'b0;
        end
        if (redir_valid) begin
            pc_d          = redir_pc;
            if_id_d.valid = 1'b0;
            case (state_q)
                S_REQ:   state_d = S_REQ;
                S_WAIT: begin
                    // A response landing with the redirect is simply dropped here.
                    if (rsp.valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d = S_REQ;
                    hold_d  = rv32i::nop;
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req.valid && imem_req_rdy) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp.valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (next_rdy) begin
                            if_id_d = '{pc: pc_q, inst: rsp.data, valid: en};
                            pc_d    = next_pc(pc_q, PC_STEP);
                            state_d = S_REQ;
                        end else begin
                            hold_d  = rsp.data;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (next_rdy) begin
                        if_id_d = '{pc: pc_q, inst: hold_q, valid: en};
                        pc_d    = next_pc(pc_q, PC_STEP);
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            hold_q  <= 32'h0;
            if_id_q <= if_id_rst;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            hold_q  <= hold_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem_req_valid = req.valid;
    assign imem_req_addr  = req.addr;
    assign if_id          = if_id_q;
    assign rdy            = en && next_rdy;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a latency-programmable memory model, a
// scoreboard of expected if_id deliveries and one task per scenario.
module tb_if_stage;
    import core::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        next_rdy;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_rdy;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    if_id_t      if_id;
    logic        rdy;

    logic        en2;
    logic        next_rdy2;
    logic        redir_valid2;
    logic [31:0] redir_pc2;
    logic        req_valid2;
    logic [31:0] req_addr2;
    logic        req_rdy2;
    logic        rsp_valid2;
    logic [31:0] rsp_data2;
    if_id_t      if_id2;
    logic        rdy2;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          cnt;
    logic        pend;
    logic [31:0] paddr;
    if_id_t      exp_q[$];
    int          cons_cyc[$];
    logic [31:0] q2[$];
    if_id_t      mon_e;
    logic        done;

    if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .en(en), .next_rdy(next_rdy),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_rdy(req_rdy),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .if_id(if_id), .rdy(rdy)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
        .clk(clk), .rst(rst), .en(en2), .next_rdy(next_rdy2),
        .redir_valid(redir_valid2), .redir_pc(redir_pc2),
        .imem_req_valid(req_valid2), .imem_req_addr(req_addr2), .imem_req_rdy(req_rdy2),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
        .if_id(if_id2), .rdy(rdy2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return 32'hA500_0013 ^ (a << 7);
    endfunction

    function automatic if_id_t mk(input logic [31:0] a);
        return '{pc: a, inst: mem_word(a), valid: 1'b1};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers each accepted request mem_lat cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            cnt       <= 0;
            paddr     <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            if (req_valid && req_rdy) begin
                if (mem_lat <= 1) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= mem_word(req_addr);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= mem_lat - 1;
                    paddr <= req_addr;
                end
            end else if (pend) begin
                if (cnt <= 1) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= mem_word(paddr);
                    pend      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // Single-cycle memory for the wrap-around instance; logs accepted addresses.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid2 <= 1'b0;
            rsp_data2  <= 32'h0;
        end else begin
            rsp_valid2 <= 1'b0;
            if (req_valid2 && req_rdy2) begin
                rsp_valid2 <= 1'b1;
                rsp_data2  <= mem_word(req_addr2);
                q2.push_back(req_addr2);
            end
        end
    end

    // Scoreboard: an if_id slot is consumed when valid while decode is ready.
    always @(negedge clk) begin
        if (!rst && if_id.valid && next_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL consume: got pc=%h inst=%h valid=1, required no delivery", if_id.pc, if_id.inst);
            end else begin
                mon_e = exp_q.pop_front();
                if (if_id !== mon_e) begin
                    errors++;
                    $display("[TB] FAIL consume: got pc=%h inst=%h, required pc=%h inst=%h", if_id.pc, if_id.inst, mon_e.pc, mon_e.inst);
                end
                cons_cyc.push_back(cyc);
            end
        end
    end

    task tick;
        @(posedge clk);
        #2;
    endtask

    task quiesce;
        en = 1'b0;
        redir_valid = 1'b0;
        next_rdy = 1'b1;
        repeat (5) tick;
    endtask

    task set_pc(input logic [31:0] a);
        redir_valid = 1'b1;
        redir_pc = a;
        tick;
        redir_valid = 1'b0;
    endtask

    task check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain: got %0d pending deliveries, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task wait_delivery(input logic [31:0] a, input string name);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick;
            if (if_id.valid && if_id.pc == a) done = 1'b1;
        end
        en = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s timeout: got no valid if_id at pc=%h, required one within 20 cycles", name, a);
        end
    endtask

    task test_reset;
        tick;
        checks++;
        if (if_id !== if_id_rst) begin
            errors++;
            $display("[TB] FAIL reset_if_id: got %h, required %h", if_id, if_id_rst);
        end
        checks++;
        if (req_addr !== 32'h0 || req_addr2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h/%h, required 00000000/fffffffc", req_addr, req_addr2);
        end
        en = 1'b1;
        #1;
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req_valid: got %b, required 0", req_valid);
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_rdy: got %b, required 1", rdy);
        end
        en = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    task test_sequential;
        quiesce;
        mem_lat = 1;
        set_pc(32'h0);
        cons_cyc.delete();
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        exp_q.push_back(mk(32'h8));
        en = 1'b1;
        wait_delivery(32'h8, "sequential");
        quiesce;
        checks++;
        if (cons_cyc.size() != 3) begin
            errors++;
            $display("[TB] FAIL seq_spacing: got %0d deliveries, required 3", cons_cyc.size());
        end else if (cons_cyc[1] - cons_cyc[0] != 2 || cons_cyc[2] - cons_cyc[1] != 2) begin
            errors++;
            $display("[TB] FAIL seq_spacing: got gaps %0d,%0d cycles, required 2,2", cons_cyc[1] - cons_cyc[0], cons_cyc[2] - cons_cyc[1]);
        end
        check_drained("sequential");
    endtask

    task test_hold;
        quiesce;
        mem_lat = 1;
        set_pc(32'h4);
        en = 1'b1;
        next_rdy = 1'b0;
        repeat (3) tick;
        checks++;
        if (if_id.valid !== 1'b0 || req_valid !== 1'b0 || rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_stall: got valid=%b req=%b rdy=%b, required 0/0/0", if_id.valid, req_valid, rdy);
        end
        exp_q.push_back(mk(32'h4));
        next_rdy = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_rdy: got %b, required 1", rdy);
        end
        tick;
        en = 1'b0;
        checks++;
        if (if_id !== mk(32'h4)) begin
            errors++;
            $display("[TB] FAIL hold_release: got %h, required %h", if_id, mk(32'h4));
        end
        quiesce;
        check_drained("hold");
    endtask

    task test_redirect_wait;
        quiesce;
        mem_lat = 3;
        set_pc(32'h40);
        en = 1'b1;
        tick;
        mem_lat = 1;
        redir_valid = 1'b1;
        redir_pc = 32'h100;
        tick;
        redir_valid = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || req_addr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL redir_wait_kill: got req=%b addr=%h, required 0/00000100", req_valid, req_addr);
        end
        exp_q.push_back(mk(32'h100));
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick;
            if (req_valid) done = 1'b1;
        end
        checks++;
        if (!done || req_addr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL redir_wait_addr: got seen=%b addr=%h, required 1/00000100", done, req_addr);
        end
        wait_delivery(32'h100, "redir_wait");
        quiesce;
        check_drained("redir_wait");
    endtask

    task test_redirect_rsp;
        quiesce;
        mem_lat = 2;
        set_pc(32'h200);
        en = 1'b1;
        tick;
        tick;
        redir_valid = 1'b1;
        redir_pc = 32'h300;
        mem_lat = 1;
        tick;
        redir_valid = 1'b0;
        #1;
        checks++;
        if (if_id.valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h300) begin
            errors++;
            $display("[TB] FAIL redir_rsp: got valid=%b req=%b addr=%h, required 0/1/00000300", if_id.valid, req_valid, req_addr);
        end
        exp_q.push_back(mk(32'h300));
        tick;
        tick;
        en = 1'b0;
        checks++;
        if (if_id !== mk(32'h300)) begin
            errors++;
            $display("[TB] FAIL redir_rsp_next: got %h, required %h", if_id, mk(32'h300));
        end
        quiesce;
        check_drained("redir_rsp");
    endtask

    task test_en_low;
        quiesce;
        mem_lat = 1;
        set_pc(32'h600);
        en = 1'b1;
        tick;
        en = 1'b0;
        tick;
        checks++;
        if (if_id !== '{pc: 32'h600, inst: mem_word(32'h600), valid: 1'b0}) begin
            errors++;
            $display("[TB] FAIL en_low_slot: got %h, required pc=00000600 inst=%h valid=0", if_id, mem_word(32'h600));
        end
        checks++;
        if (req_valid !== 1'b0 || req_addr !== 32'h604) begin
            errors++;
            $display("[TB] FAIL en_low_pc: got req=%b addr=%h, required 0/00000604", req_valid, req_addr);
        end
    endtask

    task test_async_reset;
        quiesce;
        mem_lat = 3;
        set_pc(32'h500);
        en = 1'b1;
        tick;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (if_id.valid !== 1'b0 || req_valid !== 1'b0 || req_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got valid=%b req=%b addr=%h, required 0/0/00000000", if_id.valid, req_valid, req_addr);
        end
        mem_lat = 1;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset_req: got req=%b addr=%h, required 1/00000000", req_valid, req_addr);
        end
        exp_q.push_back(mk(32'h0));
        wait_delivery(32'h0, "async_reset");
        quiesce;
        check_drained("async_reset");
    endtask

    task test_wrap;
        quiesce;
        rst = 1'b1;
        q2.delete();
        tick;
        rst = 1'b0;
        for (int i = 0; i < 20 && q2.size() < 2; i++) tick;
        checks++;
        if (q2.size() < 2) begin
            errors++;
            $display("[TB] FAIL wrap_fetch: got %0d requests, required 2", q2.size());
        end else if (q2[0] !== 32'hFFFF_FFFC || q2[1] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_fetch: got %h,%h, required fffffffc,00000000", q2[0], q2[1]);
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        next_rdy = 1'b1;
        redir_valid = 1'b0;
        redir_pc = 32'h0;
        req_rdy = 1'b1;
        en2 = 1'b1;
        next_rdy2 = 1'b1;
        redir_valid2 = 1'b0;
        redir_pc2 = 32'h0;
        req_rdy2 = 1'b1;
        #1;
        rst = 1'b1;
        test_reset;
        test_sequential;
        test_hold;
        test_redirect_wait;
        test_redirect_rsp;
        test_en_low;
        test_async_reset;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
